// File: rtl/fifo_sync_ctrl.sv
// fifo_sync_ctrl: parametrised single-clock FIFO for the UART TX/RX datapaths.
//
// Supports any DEPTH >= 2 (not only powers of two), an optional
// first-word-fall-through read mode, a fill-level output with programmable
// almost-full/almost-empty thresholds, a synchronous flush, and sticky
// overflow/underflow error flags.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   wr_en, data_in    write request and write data
//   rd_en, data_out   read request and read data (registered, or
//                     combinational from the read pointer when FWFT=1)
//   flush             synchronous clear of pointers and fill level
//   clr_err           clears the sticky error flags
//   count             fill level, 0..DEPTH
//   full, empty       count == DEPTH, count == 0
//   almost_full       count >= AF_LEVEL
//   almost_empty      count <= AE_LEVEL
//   overflow          sticky: a write was rejected
//   underflow         sticky: a read was rejected
module fifo_sync_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int FWFT       = 0,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  flush,
    input  logic                  clr_err,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [CW-1:0]         DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0]         AF_C     = CW'(AF_LEVEL);
    localparam logic [CW-1:0]         AE_C     = CW'(AE_LEVEL);

    if (DEPTH < 2) begin : g_bad_depth
        $error("fifo_sync_ctrl: DEPTH must be >= 2");
    end
    if (ADDR_WIDTH != $clog2(DEPTH)) begin : g_bad_addr_width
        $error("fifo_sync_ctrl: ADDR_WIDTH is derived from DEPTH and must not be overridden");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("fifo_sync_ctrl: AF_LEVEL must be in 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $error("fifo_sync_ctrl: AE_LEVEL must be in 0..DEPTH-1");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  rd_acc, wr_acc;
    logic                  push, pop;

    assign count        = count_q;
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    always_comb begin
        rd_acc      = rd_en && !empty;
        // A read in the same cycle frees a slot, so a full FIFO still takes the write.
        wr_acc      = wr_en && (!full || rd_acc);
        push        = wr_acc && !flush;
        pop         = rd_acc && !flush;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Explicit wrap so non-power-of-two depths stay in range.
            if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        // Set beats clear when both happen in the same cycle.
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr_en && !wr_acc && !flush) overflow_d  = 1'b1;
        if (rd_en && empty && !flush)   underflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data_in;
    end

    if (FWFT != 0) begin : g_fwft
        // Head of queue is always presented; meaningless while empty.
        assign data_out = mem_q[rd_ptr_q];
    end else begin : g_std
        logic [DATA_WIDTH-1:0] dout_q, dout_d;

        always_comb begin
            dout_d = dout_q;
            if (pop) dout_d = mem_q[rd_ptr_q];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) dout_q <= '0;
            else        dout_q <= dout_d;
        end

        assign data_out = dout_q;
    end

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
module tb_fifo_sync_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Instance A: DEPTH=16, standard read
    logic       a_wr = 0, a_rd = 0, a_fl = 0, a_clr = 0;
    logic [7:0] a_din = 0, a_dout;
    logic [4:0] a_cnt;
    logic       a_full, a_empty, a_af, a_ae, a_ovf, a_unf;

    fifo_sync_ctrl #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(0)) u_a (
        .clk(clk), .rst_n(rst_n), .wr_en(a_wr), .data_in(a_din), .rd_en(a_rd),
        .data_out(a_dout), .flush(a_fl), .clr_err(a_clr), .count(a_cnt),
        .full(a_full), .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae),
        .overflow(a_ovf), .underflow(a_unf));

    // Instance B: DEPTH=5, standard read
    logic       b_wr = 0, b_rd = 0;
    logic [7:0] b_din = 0, b_dout;
    logic [3:0] b_cnt;
    logic       b_full, b_empty, b_af, b_ae, b_ovf, b_unf;

    fifo_sync_ctrl #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(0)) u_b (
        .clk(clk), .rst_n(rst_n), .wr_en(b_wr), .data_in(b_din), .rd_en(b_rd),
        .data_out(b_dout), .flush(1'b0), .clr_err(1'b0), .count(b_cnt),
        .full(b_full), .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae),
        .overflow(b_ovf), .underflow(b_unf));

    // Instance C: DEPTH=4, first-word-fall-through
    logic       c_wr = 0, c_rd = 0;
    logic [7:0] c_din = 0, c_dout;
    logic [2:0] c_cnt;
    logic       c_full, c_empty, c_af, c_ae, c_ovf, c_unf;

    fifo_sync_ctrl #(.DATA_WIDTH(8), .DEPTH(4), .FWFT(1)) u_c (
        .clk(clk), .rst_n(rst_n), .wr_en(c_wr), .data_in(c_din), .rd_en(c_rd),
        .data_out(c_dout), .flush(1'b0), .clr_err(1'b0), .count(c_cnt),
        .full(c_full), .empty(c_empty), .almost_full(c_af), .almost_empty(c_ae),
        .overflow(c_ovf), .underflow(c_unf));

    typedef struct {
        logic       wr;
        logic [7:0] din;
        logic       rd;
        logic       fl;
        logic       clr;
        logic [4:0] cnt;
        logic       full, empty, af, ae, ovf, unf;
        logic [7:0] dout;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic wr, logic [7:0] din, logic rd, logic fl, logic clr,
                                int cnt, logic ovf, logic unf, logic [7:0] dout);
        vec_t v;
        v.wr = wr; v.din = din; v.rd = rd; v.fl = fl; v.clr = clr;
        v.cnt   = 5'(cnt);
        v.full  = (cnt == 16);
        v.empty = (cnt == 0);
        v.af    = (cnt >= 14);
        v.ae    = (cnt <= 2);
        v.ovf = ovf; v.unf = unf; v.dout = dout;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rd_exp;

        // Fill with 0x01..0x10, then a rejected 17th write.
        for (int i = 0; i < 16; i++) vecs.push_back(mk(1, 8'(i + 1), 0, 0, 0, i + 1, 0, 0, 8'h00));
        vecs.push_back(mk(1, 8'h11, 0, 0, 0, 16, 1, 0, 8'h00));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 16, 0, 0, 8'h00));
        // Read+write at full: both accepted, 0x01 out, 0xAA stored last.
        vecs.push_back(mk(1, 8'hAA, 1, 0, 0, 16, 0, 0, 8'h01));
        for (int j = 0; j < 16; j++)
            vecs.push_back(mk(0, 8'h00, 1, 0, 0, 15 - j, 0, 0, (j < 15) ? 8'(j + 2) : 8'hAA));
        // Read+write at empty: only the write is taken, underflow sets.
        vecs.push_back(mk(1, 8'h55, 1, 0, 0, 1, 0, 1, 8'hAA));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 1, 8'h55));
        // Refill, overflow, drain to 7, then flush with a write.
        for (int i = 0; i < 16; i++) vecs.push_back(mk(1, 8'(8'h20 + i), 0, 0, 0, i + 1, 0, 1, 8'h55));
        vecs.push_back(mk(1, 8'hEE, 0, 0, 0, 16, 1, 1, 8'h55));
        for (int j = 0; j < 9; j++) vecs.push_back(mk(0, 8'h00, 1, 0, 0, 15 - j, 1, 1, 8'(8'h20 + j)));
        vecs.push_back(mk(1, 8'h99, 0, 1, 0, 0, 1, 1, 8'h28));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 8'h28));
        // clr_err together with a new underflow: set wins.
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 0, 0, 1, 8'h28));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 8'h28));

        // Reset state
        #2;
        chk("rst_count", 32'(a_cnt), 0);
        chk("rst_empty", 32'(a_empty), 1);
        chk("rst_full", 32'(a_full), 0);
        chk("rst_ae", 32'(a_ae), 1);
        chk("rst_af", 32'(a_af), 0);
        chk("rst_ovf", 32'(a_ovf), 0);
        chk("rst_unf", 32'(a_unf), 0);
        chk("rst_dout", 32'(a_dout), 0);
        #10;
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            a_wr = vecs[k].wr; a_din = vecs[k].din; a_rd = vecs[k].rd;
            a_fl = vecs[k].fl; a_clr = vecs[k].clr;
            tick();
            chk($sformatf("v%0d_count", k), 32'(a_cnt),   32'(vecs[k].cnt));
            chk($sformatf("v%0d_full", k),  32'(a_full),  32'(vecs[k].full));
            chk($sformatf("v%0d_empty", k), 32'(a_empty), 32'(vecs[k].empty));
            chk($sformatf("v%0d_af", k),    32'(a_af),    32'(vecs[k].af));
            chk($sformatf("v%0d_ae", k),    32'(a_ae),    32'(vecs[k].ae));
            chk($sformatf("v%0d_ovf", k),   32'(a_ovf),   32'(vecs[k].ovf));
            chk($sformatf("v%0d_unf", k),   32'(a_unf),   32'(vecs[k].unf));
            chk($sformatf("v%0d_dout", k),  32'(a_dout),  32'(vecs[k].dout));
        end
        a_wr = 0; a_rd = 0; a_fl = 0; a_clr = 0;

        // DEPTH=5 wrap: preload 4, 19 simultaneous pairs, drain 4 (23 words total).
        for (int i = 0; i < 4; i++) begin
            b_wr = 1; b_din = 8'(i);
            tick();
        end
        b_wr = 0;
        chk("b_preload_count", 32'(b_cnt), 4);
        rd_exp = 0;
        for (int k = 0; k < 19; k++) begin
            b_wr = 1; b_din = 8'(4 + k); b_rd = 1;
            tick();
            chk($sformatf("b_pair%0d_dout", k), 32'(b_dout), 32'(rd_exp));
            chk($sformatf("b_pair%0d_count", k), 32'(b_cnt), 4);
            rd_exp++;
        end
        b_wr = 0;
        for (int k = 0; k < 4; k++) begin
            b_rd = 1;
            tick();
            chk($sformatf("b_drain%0d_dout", k), 32'(b_dout), 32'(rd_exp));
            chk($sformatf("b_drain%0d_count", k), 32'(b_cnt), 32'(3 - k));
            rd_exp++;
        end
        b_rd = 0;
        tick();
        chk("b_end_empty", 32'(b_empty), 1);
        chk("b_end_unf", 32'(b_unf), 0);
        chk("b_end_ovf", 32'(b_ovf), 0);

        // FWFT: word appears without rd_en, pop exposes the next one.
        chk("c_start_empty", 32'(c_empty), 1);
        c_wr = 1; c_din = 8'h3C;
        tick();
        c_wr = 0;
        chk("c_fall_empty", 32'(c_empty), 0);
        chk("c_fall_dout", 32'(c_dout), 32'h3C);
        tick();
        chk("c_hold_dout", 32'(c_dout), 32'h3C);
        c_rd = 1;
        tick();
        c_rd = 0;
        chk("c_pop_empty", 32'(c_empty), 1);
        c_wr = 1; c_din = 8'h7E;
        tick();
        c_din = 8'h81;
        tick();
        c_wr = 0;
        chk("c_two_dout", 32'(c_dout), 32'h7E);
        c_rd = 1;
        tick();
        c_rd = 0;
        chk("c_next_dout", 32'(c_dout), 32'h81);
        chk("c_next_count", 32'(c_cnt), 1);
        chk("c_unf", 32'(c_unf), 0);

        // Async reset mid-stream: count=9, data_out holds 0x40.
        for (int i = 0; i < 10; i++) begin
            a_wr = 1; a_din = 8'(8'h40 + i);
            tick();
        end
        a_wr = 0; a_rd = 1;
        tick();
        a_rd = 0;
        chk("ar_pre_count", 32'(a_cnt), 9);
        chk("ar_pre_dout", 32'(a_dout), 32'h40);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_count", 32'(a_cnt), 0);
        chk("ar_empty", 32'(a_empty), 1);
        chk("ar_dout", 32'(a_dout), 0);
        chk("ar_unf", 32'(a_unf), 0);
        #10;
        rst_n = 1'b1;
        tick();
        chk("ar_after_count", 32'(a_cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
